coco_line_buffer: RTL and testbench

- Ping-pong video line buffer placed directly downstream of the video memory fetch stage.
- Captures the 16-bit words the fetch stage writes during the horizontal border (BUFF_ADD / BUFF_DATA_O / BUFFER_WRITE).
- On each new border, swaps banks so the line just fetched becomes readable.
- Serves big-endian byte reads to the pixel generator during the active line, with fixed latency and fill accounting.

---
 rtl/coco_vid_pkg.sv | 25 ++
 rtl/coco_line_dpram.sv | 34 +++
 rtl/coco_line_buffer.sv | 189 ++++++++++++++++++
 tb/tb_coco_line_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coco_vid_pkg.sv
// ---------------------------------------------------------------------------
// coco_vid_pkg
// Shared constants and types for the video line buffer slice.
//   LINE_BUF_WORDS : words in one line-buffer bank
//   WORDS_160/320  : common line lengths (words per active line)
//   bank_t         : ping-pong bank selector
//   byte_idx_t     : byte index within a line (0..1023)
//   rd_stage_t     : one stage of the read pipeline (request, byte lane, range)
// ---------------------------------------------------------------------------
package coco_vid_pkg;

  localparam int LINE_BUF_WORDS = 512;
  localparam int WORDS_160      = 160;
  localparam int WORDS_320      = 320;

  typedef logic       bank_t;
  typedef logic [9:0] byte_idx_t;

  typedef struct packed {
    logic vld;  // a read request occupies this stage
    logic odd;  // low byte of the word requested
    logic oor;  // request addressed beyond the filled part of the line
  } rd_stage_t;

endpackage

// File: rtl/coco_line_dpram.sv
// ---------------------------------------------------------------------------
// coco_line_dpram
// Simple dual-port RAM, one write port and one registered read port, both on
// fast_clk. The top-level uses the address MSB as the ping-pong bank bit.
// Contents are not reset; read-during-write to one address is don't-care.
//   fast_clk  : clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address, sampled every cycle
//   rd_data_o : read data, one cycle after rd_addr_i
// ---------------------------------------------------------------------------
module coco_line_dpram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          fast_clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge fast_clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/coco_line_buffer.sv
// ---------------------------------------------------------------------------
// coco_line_buffer
// Ping-pong line buffer between the video fetch stage and the pixel generator.
// The fetch stage fills the write bank during the horizontal border; the
// rising edge of HBORDER swaps banks so the line just fetched becomes the
// read bank. Byte reads are served big-endian with a fixed 2-cycle latency.
//
// Ports
//   fast_clk       : clock, all state on the rising edge
//   RESET          : asynchronous, active-high reset
//   BUFF_ADD       : word write address
//   BUFF_DATA_I    : word write data
//   BUFFER_WRITE   : write strobe
//   HBORDER        : horizontal border level; rising edge swaps banks
//   VID_RD_EN      : byte read request
//   VID_RD_ADDR    : byte index within the line
//   VID_DATA_O     : read byte (00 for out-of-range requests)
//   VID_DATA_VALID : VID_DATA_O carries a response this cycle
//   LINE_WORDS     : words written into the current read bank
//   OVERRUN        : sticky, current write bank received more than WORD_LIMIT words
//   UNDERRUN       : sticky, a read went beyond the filled part of the read bank
// ---------------------------------------------------------------------------
module coco_line_buffer
  import coco_vid_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int WORD_LIMIT = WORDS_320
) (
  input  logic              fast_clk,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] BUFF_ADD,
  input  logic [DATA_W-1:0] BUFF_DATA_I,
  input  logic              BUFFER_WRITE,
  input  logic              HBORDER,
  input  logic              VID_RD_EN,
  input  logic [ADDR_W:0]   VID_RD_ADDR,
  output logic [7:0]        VID_DATA_O,
  output logic              VID_DATA_VALID,
  output logic [ADDR_W:0]   LINE_WORDS,
  output logic              OVERRUN,
  output logic              UNDERRUN
);

  // Counts are one bit wider than the bank address so a full bank reads
  // as 512 instead of wrapping to 0.
  localparam int               CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WORD_LIMIT);

  // -------------------------------------------------------------------------
  // Bank control and fill accounting
  // -------------------------------------------------------------------------
  bank_t            wr_bank_q, wr_bank_d;
  bank_t            rd_bank;
  logic             hb_q;
  logic             swap;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic [CNT_W-1:0] wr_count_inc;
  logic [CNT_W-1:0] wr_count_after;
  logic [CNT_W-1:0] line_words_q, line_words_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;
  logic             ovr_evt;
  logic             udr_evt;

  assign rd_bank = ~wr_bank_q;
  assign swap    = HBORDER & ~hb_q;

  assign wr_count_inc   = (wr_count_q == FULL_C) ? wr_count_q : wr_count_q + 1'b1;
  // Count including a write in this cycle; this is what a swap publishes.
  assign wr_count_after = BUFFER_WRITE ? wr_count_inc : wr_count_q;

  // Compared against the count before this write, so the (LIMIT+1)th word
  // is the first one flagged.
  assign ovr_evt = BUFFER_WRITE & (wr_count_q >= LIMIT_C);

  always_comb begin
    wr_bank_d    = wr_bank_q;
    wr_count_d   = wr_count_after;
    line_words_d = line_words_q;
    if (swap) begin
      wr_bank_d    = ~wr_bank_q;
      line_words_d = wr_count_after;
      // A write coincident with the swap lands in the old bank but still
      // counts as the first word of the new line.
      wr_count_d   = {{(CNT_W-1){1'b0}}, BUFFER_WRITE};
    end
  end

  // Sticky flags are cleared by the swap, but an event in the swap cycle
  // itself wins over the clear.
  always_comb begin
    overrun_d  = ovr_evt | (overrun_q  & ~swap);
    underrun_d = udr_evt | (underrun_q & ~swap);
  end

  always_ff @(posedge fast_clk or posedge RESET) begin
    if (RESET) begin
      wr_bank_q    <= 1'b0;
      hb_q         <= 1'b0;
      wr_count_q   <= '0;
      line_words_q <= '0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      hb_q         <= HBORDER;
      wr_count_q   <= wr_count_d;
      line_words_q <= line_words_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

  // -------------------------------------------------------------------------
  // Storage: both banks in one RAM, bank bit on the address MSB
  // -------------------------------------------------------------------------
  logic [ADDR_W:0]   ram_wr_addr;
  logic [ADDR_W:0]   ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;

  assign ram_wr_addr = {wr_bank_q, BUFF_ADD};
  assign ram_rd_addr = {rd_bank, VID_RD_ADDR[ADDR_W:1]};

  coco_line_dpram #(
    .AW (ADDR_W + 1),
    .DW (DATA_W)
  ) u_dpram (
    .fast_clk  (fast_clk),
    .wr_en_i   (BUFFER_WRITE),
    .wr_addr_i (ram_wr_addr),
    .wr_data_i (BUFF_DATA_I),
    .rd_addr_i (ram_rd_addr),
    .rd_data_o (ram_rd_data)
  );

  // -------------------------------------------------------------------------
  // Read pipeline
  //   edge 0 : request sampled, RAM address presented, side info into s1
  //   edge 1 : byte selected / forced to zero, VALID asserted
  // The range check uses LINE_WORDS at request time, so a read issued in a
  // swap cycle is judged against the line it actually reads.
  // -------------------------------------------------------------------------
  rd_stage_t  s1_q, s1_d;
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    s1_d.vld = VID_RD_EN;
    s1_d.odd = VID_RD_ADDR[0];
    s1_d.oor = ({1'b0, VID_RD_ADDR[ADDR_W:1]} >= line_words_q);
  end

  assign udr_evt = s1_q.vld & s1_q.oor;

  always_comb begin
    valid_d = s1_q.vld;
    data_d  = data_q;
    if (s1_q.vld) begin
      if (s1_q.oor) begin
        data_d = 8'h00;
      end else if (s1_q.odd) begin
        data_d = ram_rd_data[7:0];
      end else begin
        data_d = ram_rd_data[DATA_W-1 -: 8];
      end
    end
  end

  always_ff @(posedge fast_clk or posedge RESET) begin
    if (RESET) begin
      s1_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      s1_q    <= s1_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign VID_DATA_O     = data_q;
  assign VID_DATA_VALID = valid_q;
  assign LINE_WORDS     = line_words_q;
  assign OVERRUN        = overrun_q;
  assign UNDERRUN       = underrun_q;

endmodule

// File: tb/tb_coco_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_coco_line_buffer
// Directed and randomized stimulus against a line-level reference model:
// two bank arrays, a fill count per line, and a queue of pending read
// responses each tagged with the clock edge at which it must appear.
// ---------------------------------------------------------------------------
module tb_coco_line_buffer;

  logic        fast_clk = 1'b0;
  logic        RESET;
  logic [8:0]  BUFF_ADD;
  logic [15:0] BUFF_DATA_I;
  logic        BUFFER_WRITE;
  logic        HBORDER;
  logic        VID_RD_EN;
  logic [9:0]  VID_RD_ADDR;
  logic [7:0]  VID_DATA_O;
  logic        VID_DATA_VALID;
  logic [9:0]  LINE_WORDS;
  logic        OVERRUN;
  logic        UNDERRUN;

  always #5 fast_clk = ~fast_clk;

  coco_line_buffer dut (
    .fast_clk       (fast_clk),
    .RESET          (RESET),
    .BUFF_ADD       (BUFF_ADD),
    .BUFF_DATA_I    (BUFF_DATA_I),
    .BUFFER_WRITE   (BUFFER_WRITE),
    .HBORDER        (HBORDER),
    .VID_RD_EN      (VID_RD_EN),
    .VID_RD_ADDR    (VID_RD_ADDR),
    .VID_DATA_O     (VID_DATA_O),
    .VID_DATA_VALID (VID_DATA_VALID),
    .LINE_WORDS     (LINE_WORDS),
    .OVERRUN        (OVERRUN),
    .UNDERRUN       (UNDERRUN)
  );

  // Reference model state
  typedef struct {
    int       due;
    logic [7:0] b;
    bit       oor;
    bit       known;
  } rd_t;

  rd_t         pend[$];
  logic [15:0] m_mem   [2][512];
  bit          m_known [2][512];
  int          m_wb, m_cnt, m_lw;
  bit          m_hb, m_ovr, m_udr;
  int          edge_n;
  int          n_vec, n_bad, n_valid_seen;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, advance the model across the rising
  // edge, compare at the following negedge.
  task automatic step(input bit wr, input int a, input int d, input bit hb,
                      input bit re, input int ra);
    bit         swap, exp_v, ovr_evt, udr_evt, kn;
    logic [7:0] exp_b;
    int         cnt_after, w;
    rd_t        it;
    BUFFER_WRITE = wr;
    BUFF_ADD     = 9'(a);
    BUFF_DATA_I  = 16'(d);
    HBORDER      = hb;
    VID_RD_EN    = re;
    VID_RD_ADDR  = 10'(ra);
    @(posedge fast_clk);
    swap = hb && !m_hb;
    m_hb = hb;
    exp_v = 0; udr_evt = 0; kn = 0; exp_b = 8'h00;
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      it      = pend.pop_front();
      exp_v   = 1;
      exp_b   = it.b;
      kn      = it.known;
      udr_evt = it.oor;
    end
    if (re) begin
      w      = (ra % 1024) / 2;
      it.due = edge_n + 1;
      it.oor = (w >= m_lw);
      if (it.oor) begin
        it.b     = 8'h00;
        it.known = 1;
      end else begin
        it.b     = (ra % 2 == 0) ? m_mem[1-m_wb][w][15:8] : m_mem[1-m_wb][w][7:0];
        it.known = m_known[1-m_wb][w];
      end
      pend.push_back(it);
    end
    ovr_evt   = wr && (m_cnt >= 320);
    cnt_after = m_cnt + ((wr && m_cnt < 512) ? 1 : 0);
    if (wr) begin
      m_mem[m_wb][a % 512]   = 16'(d);
      m_known[m_wb][a % 512] = 1;
    end
    if (swap) begin
      m_lw  = cnt_after;
      m_cnt = wr ? 1 : 0;
      m_wb  = 1 - m_wb;
    end else begin
      m_cnt = cnt_after;
    end
    m_ovr = ovr_evt || (m_ovr && !swap);
    m_udr = udr_evt || (m_udr && !swap);
    edge_n++;
    @(negedge fast_clk);
    check("valid", 16'(VID_DATA_VALID), 16'(exp_v));
    if (VID_DATA_VALID === 1'b1) n_valid_seen++;
    if (exp_v && kn) check("rd_byte", 16'(VID_DATA_O), 16'(exp_b));
    check("line_words", 16'(LINE_WORDS), 16'(m_lw));
    check("overrun", 16'(OVERRUN), 16'(m_ovr));
    check("underrun", 16'(UNDERRUN), 16'(m_udr));
  endtask

  task automatic idle(input bit hb);
    step(0, 0, 0, hb, 0, 0);
  endtask

  // Asserted at a negedge for one full cycle; outputs must clear at once.
  task automatic do_reset();
    BUFFER_WRITE = 0; BUFF_ADD = '0; BUFF_DATA_I = '0;
    HBORDER = 0; VID_RD_EN = 0; VID_RD_ADDR = '0;
    RESET = 1'b1;
    #1;
    check("rst_valid", 16'(VID_DATA_VALID), 16'd0);
    check("rst_data", 16'(VID_DATA_O), 16'd0);
    check("rst_line_words", 16'(LINE_WORDS), 16'd0);
    check("rst_overrun", 16'(OVERRUN), 16'd0);
    check("rst_underrun", 16'(UNDERRUN), 16'd0);
    @(posedge fast_clk);
    @(negedge fast_clk);
    RESET = 1'b0;
    pend.delete();
    m_wb = 0; m_cnt = 0; m_lw = 0;
    m_hb = 0; m_ovr = 0; m_udr = 0;
  endtask

  initial begin
    int  hcnt;
    bit  hb;
    int  lim;
    n_vec = 0; n_bad = 0; n_valid_seen = 0; edge_n = 0;

    do_reset();

    // 160-word line, then swap
    for (int n = 0; n < 160; n++) step(1, n, 16'h0100 + n, 0, 0, 0);
    idle(1);
    check("lw160", 16'(LINE_WORDS), 16'd160);
    check("ovr160", 16'(OVERRUN), 16'd0);

    step(0, 0, 0, 1, 1, 6);
    step(0, 0, 0, 1, 1, 7);
    check("byte6", 16'(VID_DATA_O), 16'h01);
    idle(1);
    check("byte7", 16'(VID_DATA_O), 16'h03);

    // Back-to-back byte reads across the whole line
    n_valid_seen = 0;
    for (int i = 0; i < 320; i++) step(0, 0, 0, 1, 1, i);
    idle(1);
    idle(1);
    check("burst_valids", 16'(n_valid_seen), 16'd320);

    // Reads past the filled part of the line
    step(0, 0, 0, 1, 1, 320);
    step(0, 0, 0, 1, 1, 321);
    check("udr_set", 16'(UNDERRUN), 16'd1);
    idle(1);
    check("oor_byte", 16'(VID_DATA_O), 16'h00);
    idle(0);
    idle(1);
    check("udr_clr", 16'(UNDERRUN), 16'd0);

    // 321-word line with random reads of the (empty) read bank
    idle(0);
    for (int n = 0; n < 321; n++) begin
      step(1, n, $urandom, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 1023));
      if (n == 319) check("ovr_pre", 16'(OVERRUN), 16'd0);
      if (n == 320) check("ovr_set", 16'(OVERRUN), 16'd1);
    end
    idle(1);
    check("lw321", 16'(LINE_WORDS), 16'd321);
    check("ovr_clr", 16'(OVERRUN), 16'd0);

    // Write coincident with the swap
    idle(0);
    for (int n = 0; n < 10; n++) step(1, n, $urandom, 0, 0, 0);
    step(1, 10, 16'hBEEF, 1, 0, 0);
    check("lw_coinc", 16'(LINE_WORDS), 16'd11);
    step(0, 0, 0, 1, 1, 20);
    step(0, 0, 0, 1, 1, 21);
    check("coinc_hi", 16'(VID_DATA_O), 16'h00BE);
    idle(1);
    check("coinc_lo", 16'(VID_DATA_O), 16'h00EF);
    idle(0);
    step(1, 0, $urandom, 1, 0, 0);
    check("cnt_after_coinc", 16'(LINE_WORDS), 16'd2);

    // Randomized lines: border pulses, writes, reads in and out of range
    hb = 1; hcnt = 3;
    for (int i = 0; i < 4000; i++) begin
      if (hcnt == 0) begin
        hb   = !hb;
        hcnt = hb ? $urandom_range(1, 5) : $urandom_range(20, 700);
      end
      hcnt--;
      lim = 2 * m_lw + 20;
      if (lim > 1023) lim = 1023;
      step(($urandom_range(0, 9) < 6), $urandom_range(0, 511), $urandom, hb,
           ($urandom_range(0, 9) < 7), $urandom_range(0, lim));
    end

    // Reset in the middle of a write+read burst
    idle(0);
    for (int n = 0; n < 20; n++) step(1, n, $urandom, 0, 0, 0);
    idle(1);
    idle(0);
    for (int n = 0; n < 6; n++) step(1, 100 + n, $urandom, 0, 1, n);
    do_reset();
    step(0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 1, 3);
    idle(0);
    check("lw_after_rst", 16'(LINE_WORDS), 16'd0);
    for (int n = 0; n < 5; n++) step(1, n, 16'h5A00 + n, 0, 0, 0);
    idle(1);
    check("lw_post_rst_line", 16'(LINE_WORDS), 16'd5);
    step(0, 0, 0, 1, 1, 9);
    idle(1);
    check("post_rst_byte", 16'(VID_DATA_O), 16'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
